// File: rtl/alu_writeback.sv
// ALU writeback stage: 2-entry result buffer toward the register file plus architectural flags.
// Latency one cycle in to wb_*; in_ready depends only on occupancy, so wb_ready never reaches it combinationally.

package definitions_pkg;
  localparam logic [3:0] kADD   = 4'd0;
  localparam logic [3:0] kADC   = 4'd1;
  localparam logic [3:0] kSUB   = 4'd2;
  localparam logic [3:0] kAND   = 4'd3;
  localparam logic [3:0] kOR    = 4'd4;
  localparam logic [3:0] kXOR   = 4'd5;
  localparam logic [3:0] kMOV   = 4'd6;
  localparam logic [3:0] kCMP   = 4'd7;
  localparam logic [3:0] kSHIFT = 4'd8;
endpackage

module alu_writeback
  import definitions_pkg::*;
#(
  parameter int DATA_PATH_WIDTH = 8,
  parameter int REG_ADDR_WIDTH  = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_op,
  input  logic [REG_ADDR_WIDTH-1:0]  in_rd,
  input  logic [DATA_PATH_WIDTH-1:0] in_result,
  input  logic                       in_carry,
  input  logic                       in_lt,
  input  logic                       in_gt,
  input  logic                       in_eq,
  input  logic                       flush,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [REG_ADDR_WIDTH-1:0]  wb_addr,
  output logic [DATA_PATH_WIDTH-1:0] wb_data,
  output logic                       carry_flag,
  output logic                       lt_flag,
  output logic                       gt_flag,
  output logic                       eq_flag,
  output logic [15:0]                retire_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0]  addr;
    logic [DATA_PATH_WIDTH-1:0] data;
  } entry_t;

  state_t state, state_nxt;
  entry_t head, tail, new_entry;

  logic writes_rf, sets_carry, sets_cmp;
  logic accept, push, pop;

  always_comb begin
    writes_rf  = 1'b0;
    sets_carry = 1'b0;
    sets_cmp   = 1'b0;
    case (in_op)
      kADD, kADC, kSHIFT: begin
        writes_rf  = 1'b1;
        sets_carry = 1'b1;
      end
      kSUB, kAND, kOR, kXOR, kMOV: writes_rf = 1'b1;
      kCMP:    sets_cmp = 1'b1;
      default: ;
    endcase
  end

  assign new_entry = '{addr: in_rd, data: in_result};
  assign accept    = in_valid && in_ready && !flush;
  assign push      = accept && writes_rf;
  assign pop       = wb_valid && wb_ready && !flush;

  // Occupancy FSM; handshake outputs are a pure function of state.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b1;
    wb_valid  = 1'b0;
    case (state)
      EMPTY: begin
        if (push) state_nxt = ONE;
      end
      ONE: begin
        wb_valid = 1'b1;
        if (push && !pop)      state_nxt = FULL;
        else if (pop && !push) state_nxt = EMPTY;
      end
      FULL: begin
        wb_valid = 1'b1;
        in_ready = 1'b0;
        if (pop) state_nxt = ONE;
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush) state_nxt = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= EMPTY;
      head         <= '0;
      tail         <= '0;
      carry_flag   <= 1'b0;
      lt_flag      <= 1'b0;
      gt_flag      <= 1'b0;
      eq_flag      <= 1'b0;
      retire_count <= '0;
    end else begin
      state <= state_nxt;
      // Head is always the oldest entry; tail only ever holds the second one.
      if (push && (state == EMPTY || (state == ONE && pop))) head <= new_entry;
      else if (push && state == ONE)                         tail <= new_entry;
      else if (pop && state == FULL)                         head <= tail;
      if (accept && sets_carry) carry_flag <= in_carry;
      if (accept && sets_cmp) begin
        lt_flag <= in_lt;
        gt_flag <= in_gt;
        eq_flag <= in_eq;
      end
      if (pop) retire_count <= retire_count + 16'd1;
    end
  end

  assign wb_addr = wb_valid ? head.addr : '0;
  assign wb_data = wb_valid ? head.data : '0;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: hand-computed expectations checked after each rising edge.
module tb_alu_writeback;
  import definitions_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [2:0]  in_rd;
  logic [7:0]  in_result;
  logic        in_carry, in_lt, in_gt, in_eq;
  logic        flush;
  logic        wb_valid;
  logic        wb_ready;
  logic [2:0]  wb_addr;
  logic [7:0]  wb_data;
  logic        carry_flag, lt_flag, gt_flag, eq_flag;
  logic [15:0] retire_count;

  int errors = 0;
  int checks = 0;

  alu_writeback #(.DATA_PATH_WIDTH(8), .REG_ADDR_WIDTH(3)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_result(in_result), .in_carry(in_carry), .in_lt(in_lt), .in_gt(in_gt), .in_eq(in_eq),
    .flush(flush),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .carry_flag(carry_flag), .lt_flag(lt_flag), .gt_flag(gt_flag), .eq_flag(eq_flag),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [2:0] rd,
                       input logic [7:0] res, input logic c);
    in_valid  = v;
    in_op     = op;
    in_rd     = rd;
    in_result = res;
    in_carry  = c;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; wb_ready = 1'b0;
    in_lt = 1'b0; in_gt = 1'b0; in_eq = 1'b0;
    drive(1'b0, kADD, 3'd0, 8'h00, 1'b0);
    step(); step();
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_addr", wb_addr, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_flags", {carry_flag, lt_flag, gt_flag, eq_flag}, 0);
    chk("rst_retire", retire_count, 0);
    reset = 1'b0;
    step();
    chk("rst_in_ready", in_ready, 1);

    // Single kADD flows through in one cycle and retires.
    wb_ready = 1'b1;
    drive(1'b1, kADD, 3'd2, 8'h10, 1'b1);
    step();
    chk("add_wb_valid", wb_valid, 1);
    chk("add_wb_addr", wb_addr, 2);
    chk("add_wb_data", wb_data, 8'h10);
    chk("add_carry", carry_flag, 1);
    in_valid = 1'b0;
    step();
    chk("add_retire", retire_count, 1);
    chk("add_empty_valid", wb_valid, 0);
    chk("add_empty_data", wb_data, 0);

    // Fill to FULL under backpressure, then drain in order.
    wb_ready = 1'b0;
    drive(1'b1, kMOV, 3'd1, 8'hA1, 1'b0);
    step();
    drive(1'b1, kMOV, 3'd2, 8'hA2, 1'b0);
    step();
    chk("full_in_ready", in_ready, 0);
    chk("full_head", wb_data, 8'hA1);
    drive(1'b1, kMOV, 3'd3, 8'hA3, 1'b0);
    step();
    chk("full_hold_data", wb_data, 8'hA1);
    chk("full_hold_addr", wb_addr, 1);
    chk("full_hold_ready", in_ready, 0);
    wb_ready = 1'b1;
    step();
    chk("drain1_data", wb_data, 8'hA2);
    chk("drain1_ready", in_ready, 1);
    chk("drain1_retire", retire_count, 2);
    step();
    chk("drain2_data", wb_data, 8'hA3);
    chk("drain2_addr", wb_addr, 3);
    chk("drain2_retire", retire_count, 3);
    in_valid = 1'b0;
    step();
    chk("drain3_valid", wb_valid, 0);
    chk("drain3_retire", retire_count, 4);
    chk("mov_keeps_carry", carry_flag, 1);

    // kSHIFT clears carry; kCMP pushes nothing; kSUB leaves carry alone.
    drive(1'b1, kSHIFT, 3'd4, 8'h80, 1'b0);
    step();
    chk("shift_carry", carry_flag, 0);
    chk("shift_data", wb_data, 8'h80);
    drive(1'b1, kCMP, 3'd5, 8'hEE, 1'b1);
    in_lt = 1'b1;
    step();
    chk("cmp_no_push", wb_valid, 0);
    chk("cmp_retire", retire_count, 5);
    chk("cmp_flags", {lt_flag, gt_flag, eq_flag}, 3'b100);
    chk("cmp_carry", carry_flag, 0);
    drive(1'b1, kSUB, 3'd6, 8'h3C, 1'b1);
    in_lt = 1'b0; in_eq = 1'b1;
    step();
    chk("sub_addr", wb_addr, 6);
    chk("sub_data", wb_data, 8'h3C);
    chk("sub_carry", carry_flag, 0);
    chk("sub_flags", {lt_flag, gt_flag, eq_flag}, 3'b100);
    drive(1'b1, kCMP, 3'd0, 8'h00, 1'b0);
    in_gt = 1'b1; in_eq = 1'b0;
    step();
    chk("cmp2_flags", {lt_flag, gt_flag, eq_flag}, 3'b010);
    chk("cmp2_empty", wb_valid, 0);
    chk("cmp2_retire", retire_count, 6);
    in_gt = 1'b0;

    // Back-to-back kADD then kADC: carry visible the very next cycle.
    drive(1'b1, kADD, 3'd1, 8'hFF, 1'b1);
    step();
    chk("adc_prev_carry", carry_flag, 1);
    drive(1'b1, kADC, 3'd2, 8'h01, 1'b0);
    step();
    chk("adc_carry", carry_flag, 0);
    chk("adc_data", wb_data, 8'h01);
    in_valid = 1'b0;
    step();
    chk("adc_retire", retire_count, 8);

    // Simultaneous push and pop in ONE.
    wb_ready = 1'b0;
    drive(1'b1, kAND, 3'd1, 8'h11, 1'b0);
    step();
    wb_ready = 1'b1;
    drive(1'b1, kOR, 3'd7, 8'h22, 1'b0);
    step();
    chk("pp_valid", wb_valid, 1);
    chk("pp_in_ready", in_ready, 1);
    chk("pp_data", wb_data, 8'h22);
    chk("pp_addr", wb_addr, 7);
    chk("pp_retire", retire_count, 9);
    in_valid = 1'b0;
    step();
    chk("pp_drain", retire_count, 10);

    // Flush from FULL with a carry-setting input.
    wb_ready = 1'b0;
    drive(1'b1, kXOR, 3'd1, 8'h5A, 1'b0);
    step();
    drive(1'b1, kXOR, 3'd2, 8'h5B, 1'b0);
    step();
    chk("fl_full", in_ready, 0);
    flush = 1'b1; wb_ready = 1'b1;
    drive(1'b1, kADD, 3'd3, 8'h77, 1'b1);
    step();
    chk("fl_valid", wb_valid, 0);
    chk("fl_data", wb_data, 0);
    chk("fl_carry", carry_flag, 0);
    chk("fl_retire", retire_count, 10);
    // Flush in ONE where the input would otherwise be accepted.
    flush = 1'b0; wb_ready = 1'b0;
    drive(1'b1, kMOV, 3'd4, 8'h44, 1'b0);
    step();
    flush = 1'b1; wb_ready = 1'b1;
    drive(1'b1, kADD, 3'd5, 8'h55, 1'b1);
    step();
    chk("fl1_valid", wb_valid, 0);
    chk("fl1_carry", carry_flag, 0);
    chk("fl1_retire", retire_count, 10);
    flush = 1'b0;

    // Stream one pop per cycle up to 16'hFFFF, then wrap.
    drive(1'b1, kMOV, 3'd1, 8'h99, 1'b0);
    step();
    repeat (16'hFFFF - 10) step();
    chk("wrap_max", retire_count, 16'hFFFF);
    step();
    chk("wrap_zero", retire_count, 16'h0000);
    in_valid = 1'b0;
    step();
    chk("wrap_one", retire_count, 16'h0001);

    // Reset in the middle of a FULL buffer with flags set.
    wb_ready = 1'b0;
    in_lt = 1'b1;
    drive(1'b1, kCMP, 3'd0, 8'h00, 1'b0);
    step();
    in_lt = 1'b0;
    drive(1'b1, kADD, 3'd3, 8'hC3, 1'b1);
    step();
    drive(1'b1, kSUB, 3'd4, 8'hC4, 1'b0);
    step();
    chk("pre_rst_full", in_ready, 0);
    chk("pre_rst_flags", {carry_flag, lt_flag}, 2'b11);
    reset = 1'b1; flush = 1'b1; wb_ready = 1'b1;
    drive(1'b1, kADD, 3'd5, 8'hC5, 1'b1);
    step();
    chk("mid_rst_valid", wb_valid, 0);
    chk("mid_rst_addr", wb_addr, 0);
    chk("mid_rst_data", wb_data, 0);
    chk("mid_rst_flags", {carry_flag, lt_flag, gt_flag, eq_flag}, 0);
    chk("mid_rst_retire", retire_count, 0);
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    step();
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_valid", wb_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
